regfile_writeback_queue: RTL and testbench

// - Write side of the 32x32 register file. Buffers pipeline writeback requests and drains them
//   one per cycle onto the register-file write port (r_wr_en/w_reg/w_data).
// - Forwards pending (queued or in-flight) write data to the two register-file read addresses,
//   so decode sees the value that will land in the register file rather than a stale one.

---
 rtl/regfile_writeback_queue_if.sv | 31 +++
 rtl/regfile_writeback_queue.sv | 120 ++++++++++++
 tb/tb_regfile_writeback_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_queue_if.sv
// Bus between the pipeline/decode side and the register-file writeback queue:
// writeback handshake, register-file write port and the two forwarding read ports.
interface regfile_writeback_queue_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          rf_stall;
  logic          r_wr_en;
  logic [AW-1:0] w_reg;
  logic [DW-1:0] w_data;
  logic [AW-1:0] r_reg1;
  logic [AW-1:0] r_reg2;
  logic          fwd1_hit;
  logic [DW-1:0] fwd1_data;
  logic          fwd2_hit;
  logic [DW-1:0] fwd2_data;

  modport master (
    output wb_valid, wb_reg, wb_data, rf_stall, r_reg1, r_reg2,
    input  wb_ready, r_wr_en, w_reg, w_data, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, rf_stall, r_reg1, r_reg2,
    output wb_ready, r_wr_en, w_reg, w_data, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Writeback queue for the 32x32 register file: buffers writes, drains one per cycle through a
// registered output stage, and forwards pending data to the two read addresses.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_writeback_queue_if.slave     bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0] reg_mem [DEPTH];
  logic [DW-1:0] data_mem[DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q;
  logic [AW-1:0] w_reg_q;
  logic [DW-1:0] w_data_q;
  logic          push, pop;

  assign bus.wb_ready = !rst && (count_q < CW'(DEPTH));
  // Writes to x0 complete the handshake but are dropped.
  assign push = bus.wb_valid && bus.wb_ready && (bus.wb_reg != '0);
  assign pop  = !bus.rf_stall && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wr_en_q  <= 1'b0;
      w_reg_q  <= '0;
      w_data_q <= '0;
    end else begin
      count_q <= count_d;
      wr_en_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        w_reg_q  <= reg_mem[rd_ptr_q];
        w_data_q <= data_mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr_q]  <= bus.wb_reg;
      data_mem[wr_ptr_q] <= bus.wb_data;
    end
  end

  assign bus.r_wr_en = wr_en_q;
  assign bus.w_reg   = w_reg_q;
  assign bus.w_data  = w_data_q;
  assign count       = count_q;

  // Scan oldest to youngest so the last match (youngest) wins.
  logic          hit1, hit2;
  logic [DW-1:0] dat1, dat2;
  logic [PW-1:0] idx;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    dat1 = '0;
    dat2 = '0;
    idx  = '0;
    if (wr_en_q && (w_reg_q == bus.r_reg1)) begin
      hit1 = 1'b1;
      dat1 = w_data_q;
    end
    if (wr_en_q && (w_reg_q == bus.r_reg2)) begin
      hit2 = 1'b1;
      dat2 = w_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (reg_mem[idx] == bus.r_reg1) begin
          hit1 = 1'b1;
          dat1 = data_mem[idx];
        end
        if (reg_mem[idx] == bus.r_reg2) begin
          hit2 = 1'b1;
          dat2 = data_mem[idx];
        end
      end
    end
    if (bus.r_reg1 == '0) begin
      hit1 = 1'b0;
      dat1 = '0;
    end
    if (bus.r_reg2 == '0) begin
      hit2 = 1'b0;
      dat2 = '0;
    end
  end

  assign bus.fwd1_hit  = hit1;
  assign bus.fwd1_data = dat1;
  assign bus.fwd2_hit  = hit2;
  assign bus.fwd2_data = dat2;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: latency, backpressure, forwarding, x0 drop,
// pointer wrap and mid-operation reset.
module tb_regfile_writeback_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] count;
  int         total  = 0;
  int         passed = 0;

  regfile_writeback_queue_if #(.AW(5), .DW(32)) bus ();

  regfile_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wb_valid = 1'b0;
    bus.wb_reg   = '0;
    bus.wb_data  = '0;
    bus.rf_stall = 1'b0;
    bus.r_reg1   = '0;
    bus.r_reg2   = '0;

    // Reset state
    step();
    step();
    check("rst_ready", 32'(bus.wb_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_wr_en", 32'(bus.r_wr_en), 32'd0);
    check("rst_w_reg", 32'(bus.w_reg), 32'd0);
    check("rst_w_data", bus.w_data, 32'd0);
    rst = 1'b0;
    step();

    // Single write latency
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd3;
    bus.wb_data  = 32'hDEADBEEF;
    #1;
    check("single_ready", 32'(bus.wb_ready), 32'd1);
    step();
    bus.wb_valid = 1'b0;
    bus.r_reg1   = 5'd3;
    #1;
    check("single_count1", 32'(count), 32'd1);
    check("single_wr_en_early", 32'(bus.r_wr_en), 32'd0);
    check("single_fwd_hit", 32'(bus.fwd1_hit), 32'd1);
    check("single_fwd_data", bus.fwd1_data, 32'hDEADBEEF);
    step();
    check("single_wr_en", 32'(bus.r_wr_en), 32'd1);
    check("single_w_reg", 32'(bus.w_reg), 32'd3);
    check("single_w_data", bus.w_data, 32'hDEADBEEF);
    check("single_count0", 32'(count), 32'd0);
    step();
    check("single_one_cycle", 32'(bus.r_wr_en), 32'd0);
    check("single_w_reg_hold", 32'(bus.w_reg), 32'd3);

    // Fill under stall, 5th request waits, then ordered drain
    bus.rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'(i);
      bus.wb_data  = 32'h100 + 32'(i);
      step();
    end
    bus.wb_reg  = 5'd7;
    bus.wb_data = 32'h700;
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(bus.wb_ready), 32'd0);
    step();
    check("full_wait_count", 32'(count), 32'd4);
    check("full_stall_wr_en", 32'(bus.r_wr_en), 32'd0);
    bus.r_reg1 = 5'd2;
    #1;
    check("full_fwd_data", bus.fwd1_data, 32'h102);
    bus.rf_stall = 1'b0;
    step();
    bus.r_reg2 = 5'd1;
    #1;
    check("drain1_w_reg", 32'(bus.w_reg), 32'd1);
    check("drain1_w_data", bus.w_data, 32'h101);
    check("drain1_count", 32'(count), 32'd3);
    check("drain1_ready", 32'(bus.wb_ready), 32'd1);
    check("drain1_fwd_out_hit", 32'(bus.fwd2_hit), 32'd1);
    check("drain1_fwd_out_data", bus.fwd2_data, 32'h101);
    step();
    bus.wb_valid = 1'b0;
    check("drain2_w_reg", 32'(bus.w_reg), 32'd2);
    check("drain2_count", 32'(count), 32'd3);
    step();
    check("drain3_w_reg", 32'(bus.w_reg), 32'd3);
    check("drain3_wr_en", 32'(bus.r_wr_en), 32'd1);
    step();
    check("drain4_w_reg", 32'(bus.w_reg), 32'd4);
    step();
    check("drain5_w_reg", 32'(bus.w_reg), 32'd7);
    check("drain5_w_data", bus.w_data, 32'h700);
    check("drain5_count", 32'(count), 32'd0);
    step();
    check("drain_idle", 32'(bus.r_wr_en), 32'd0);

    // Youngest-wins forwarding
    bus.rf_stall = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd5;
    bus.wb_data  = 32'h11;
    step();
    bus.wb_data  = 32'h22;
    step();
    bus.wb_reg  = 5'd6;
    bus.wb_data = 32'h66;
    bus.r_reg1  = 5'd5;
    bus.r_reg2  = 5'd6;
    #1;
    check("fwd_young_hit", 32'(bus.fwd1_hit), 32'd1);
    check("fwd_young_data", bus.fwd1_data, 32'h22);
    check("fwd_inflight_push_hit", 32'(bus.fwd2_hit), 32'd0);
    check("fwd_miss_data", bus.fwd2_data, 32'd0);
    bus.wb_valid = 1'b0;
    bus.rf_stall = 1'b0;
    step();
    check("fwd_out_plus_q_data", bus.fwd1_data, 32'h22);
    check("fwd_out_w_data", bus.w_data, 32'h11);
    step();
    check("fwd_out_only_data", bus.fwd1_data, 32'h22);
    step();
    check("fwd_after_hit", 32'(bus.fwd1_hit), 32'd0);

    // Write to x0 is dropped
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd0;
    bus.wb_data  = 32'hFFFF;
    bus.r_reg1   = 5'd0;
    #1;
    check("x0_ready", 32'(bus.wb_ready), 32'd1);
    check("x0_fwd_hit", 32'(bus.fwd1_hit), 32'd0);
    check("x0_fwd_data", bus.fwd1_data, 32'd0);
    step();
    bus.wb_valid = 1'b0;
    check("x0_count", 32'(count), 32'd0);
    step();
    check("x0_wr_en", 32'(bus.r_wr_en), 32'd0);

    // Streaming 10 writes through, wrapping pointers
    for (int i = 0; i < 10; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'(8 + i);
      bus.wb_data  = 32'hA000 + 32'(i);
      step();
      check("stream_count", 32'(count), 32'd1);
      if (i == 0) begin
        check("stream_wr_en0", 32'(bus.r_wr_en), 32'd0);
      end else begin
        check("stream_wr_en", 32'(bus.r_wr_en), 32'd1);
        check("stream_w_reg", 32'(bus.w_reg), 32'(8 + i - 1));
        check("stream_w_data", bus.w_data, 32'hA000 + 32'(i - 1));
      end
    end
    bus.wb_valid = 1'b0;
    step();
    check("stream_last_w_reg", 32'(bus.w_reg), 32'd17);
    check("stream_last_count", 32'(count), 32'd0);
    step();
    check("stream_idle", 32'(bus.r_wr_en), 32'd0);

    // Reset with 3 queued and one presented
    bus.rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'(20 + i);
      bus.wb_data  = 32'hB000 + 32'(i);
      step();
    end
    bus.wb_valid = 1'b0;
    bus.rf_stall = 1'b0;
    step();
    check("prerst_wr_en", 32'(bus.r_wr_en), 32'd1);
    check("prerst_count", 32'(count), 32'd3);
    rst = 1'b1;
    bus.r_reg1 = 5'd21;
    #1;
    check("midrst_wr_en", 32'(bus.r_wr_en), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_ready", 32'(bus.wb_ready), 32'd0);
    check("midrst_fwd_hit", 32'(bus.fwd1_hit), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("postrst_wr_en", 32'(bus.r_wr_en), 32'd0);
    end
    check("postrst_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
